// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: program memory port, redirect and decode handshake bundle
interface instruction_fetch_unit_if #(parameter int ADDR_W = 16);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [7:0]        mem_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic [7:0]        instr_opcode;
  logic [2:0]        instr_optype;
  logic [7:0]        instr_op1;
  logic [7:0]        instr_op2;
  logic [7:0]        instr_op3;
  logic [2:0]        instr_len;
  logic [ADDR_W-1:0] instr_pc;
  modport master (
    output mem_addr, mem_rd, instr_valid, instr_opcode, instr_optype,
           instr_op1, instr_op2, instr_op3, instr_len, instr_pc,
    input  mem_data, redirect, redirect_pc, instr_ready
  );
  modport slave (
    input  mem_addr, mem_rd, instr_valid, instr_opcode, instr_optype,
           instr_op1, instr_op2, instr_op3, instr_len, instr_pc,
    output mem_data, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: byte-serial variable-length instruction fetch and assembly
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                      clk,
  input logic                      rst,
  instruction_fetch_unit_if.master bus
);
  typedef enum logic [1:0] {REQ, CAP, OUT} state_t;
  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [1:0]        nops_q, nops_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d, ipc_q, ipc_d;
  logic [7:0]        opcode_q, opcode_d, op1_q, op1_d, op2_q, op2_d, op3_q, op3_d;
  logic [2:0]        optype_q, optype_d, len_q, len_d;
  logic              last_byte;
  // idx 0 = opcode, 1 = header, 2.. = operands; header with nops=0 ends the instruction
  assign last_byte = (idx_q == 3'd0) ? 1'b0 :
                     (idx_q == 3'd1) ? (bus.mem_data[4:3] == 2'd0) :
                     (idx_q == {1'b0, nops_q} + 3'd1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= REQ;
      idx_q    <= '0;
      nops_q   <= '0;
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      ipc_q    <= '0;
      opcode_q <= '0;
      optype_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      op3_q    <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      nops_q   <= nops_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      ipc_q    <= ipc_d;
      opcode_q <= opcode_d;
      optype_q <= optype_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      op3_q    <= op3_d;
      len_q    <= len_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (bus.redirect) state_d = REQ;
    else case (state_q)
      REQ:     state_d = CAP;
      CAP:     state_d = last_byte ? OUT : REQ;
      OUT:     state_d = bus.instr_ready ? REQ : OUT;
      default: state_d = REQ;
    endcase
  end
  always_comb begin
    idx_d    = idx_q;
    nops_d   = nops_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    ipc_d    = ipc_q;
    opcode_d = opcode_q;
    optype_d = optype_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    op3_d    = op3_q;
    len_d    = len_q;
    if (state_q == REQ) begin
      pc_d   = pc_q + ONE;
      addr_d = pc_q;
      if (idx_q == 3'd0) begin
        ipc_d = pc_q;
        op1_d = '0;
        op2_d = '0;
        op3_d = '0;
      end
    end
    if (state_q == CAP) begin
      idx_d = last_byte ? 3'd0 : idx_q + 3'd1;
      case (idx_q)
        3'd0: opcode_d = bus.mem_data;
        3'd1: begin
          optype_d = bus.mem_data[2:0];
          nops_d   = bus.mem_data[4:3];
          len_d    = {1'b0, bus.mem_data[4:3]} + 3'd2;
        end
        3'd2:    op1_d = bus.mem_data;
        3'd3:    op2_d = bus.mem_data;
        default: op3_d = bus.mem_data;
      endcase
    end
    // a redirect abandons any partial instruction; the in-flight read is never captured
    if (bus.redirect) begin
      pc_d  = bus.redirect_pc;
      idx_d = '0;
    end
  end
  always_comb begin
    bus.mem_rd       = (state_q == REQ) && !rst;
    bus.mem_addr     = (state_q == REQ) ? pc_q : addr_q;
    bus.instr_valid  = state_q == OUT;
    bus.instr_opcode = opcode_q;
    bus.instr_optype = optype_q;
    bus.instr_op1    = op1_q;
    bus.instr_op2    = op2_q;
    bus.instr_op3    = op3_q;
    bus.instr_len    = len_q;
    bus.instr_pc     = ipc_q;
  end
endmodule
